iterative_left_shifter: RTL

//   Multi-cycle logical left shifter for the ALU datapath; the left-direction companion to the

---
 rtl/iterative_left_shifter_if.sv | 25 ++
 rtl/iterative_left_shifter.sv | 97 +++++++++
 2 files changed

// File: rtl/iterative_left_shifter_if.sv
// Operand/result handshake bundle for the iterative left shifter.
// master drives operands and consumes results; slave is the shifter.
interface iterative_left_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_lost;

    modport master (
        output in_valid, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, out_lost
    );

    modport slave (
        input  in_valid, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data, out_lost
    );
endinterface

// File: rtl/iterative_left_shifter.sv
// Multi-cycle logical left shifter, 8/4/2/1 bits per cycle.
// Flags any 1 bit pushed out past the MSB.
module iterative_left_shifter #(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int STEP_MAX = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    iterative_left_shifter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;
    logic               lost;
    logic [SHAMT_W-1:0] step;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   keep_mask;
    logic               step_lost;
    logic               accept;

    assign accept    = bus.in_valid && (state == IDLE);
    assign rem_next  = rem - step;
    assign keep_mask = {WIDTH{1'b1}} >> step;
    assign step_lost = |(acc & ~keep_mask);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;
    assign bus.out_lost  = lost;

    // Largest power-of-two step not exceeding the remaining amount.
    always_comb begin
        step = SHAMT_W'(1);
        for (int i = 0; (1 << i) <= STEP_MAX; i++) begin
            if (rem >= SHAMT_W'(1 << i)) begin
                step = SHAMT_W'(1 << i);
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and per-cycle shift datapath.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc  <= '0;
            rem  <= '0;
            lost <= 1'b0;
        end else if (accept) begin
            acc  <= bus.in_data;
            rem  <= bus.in_shamt;
            lost <= 1'b0;
        end else if (state == SHIFT) begin
            acc  <= acc << step;
            rem  <= rem_next;
            lost <= lost | step_lost;
        end
    end
endmodule
